// File: rtl/pkt_priority_queue_pkg.sv
// ---------------------------------------------------------------------------
// pkt_h : shared types for the packet priority queue.
//   PRIOR_WIDTH  width of the priority key extracted from a header
//   pkHeadInfo   256-bit packet header (8 x 32-bit words, last word = prior)
//   get_prior()  priority key of a header (low PRIOR_WIDTH bits of prior)
//   pq_entry_t   canonical stored entry {header, 64-bit data, prior}
//   slot_sel_e   per-slot next-state selection
// ---------------------------------------------------------------------------
package pkt_h;

  localparam int PRIOR_WIDTH = 16;
  localparam int PQ_DWIDTH   = 64;

  typedef struct packed {
    logic [31:0] flow_id;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] pkt_len;
    logic [31:0] flags;
    logic [31:0] ts_hi;
    logic [31:0] ts_lo;
    logic [31:0] prior;
  } pkHeadInfo;

  typedef struct packed {
    pkHeadInfo              hdr;
    logic [PQ_DWIDTH-1:0]   data;
    logic [PRIOR_WIDTH-1:0] prior;
  } pq_entry_t;

  // HOLD  : keep current contents
  // NEW   : load the incoming entry
  // LEFT  : load slot i-1 (entries shifting up behind an insert)
  // RIGHT : load slot i+1 (entries shifting down on a dequeue)
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_NEW   = 2'd1,
    SEL_LEFT  = 2'd2,
    SEL_RIGHT = 2'd3
  } slot_sel_e;

  function automatic logic [PRIOR_WIDTH-1:0] get_prior(input pkHeadInfo h);
    return PRIOR_WIDTH'(h.prior);
  endfunction

endpackage

// File: rtl/pkt_priority_queue_slot.sv
// ---------------------------------------------------------------------------
// pq_slot : one storage slot of the sorted priority queue.
//   clk, rst          clock, asynchronous active-low reset
//   i_sel             next-state selection (hold/new/left/right)
//   i_new_*           incoming entry (header, data, prior)
//   i_left_*          contents of slot i-1
//   i_right_*         contents of slot i+1
//   o_valid/o_hdr/
//   o_data/o_prior    registered contents of this slot
//   o_ins             1 = new entry belongs at or before this slot
//                     (slot empty, or new prior strictly below stored prior)
// Invalid slots always hold all-zero contents, so shifting an empty
// neighbour in clears the slot without extra logic.
// ---------------------------------------------------------------------------
module pq_slot
  import pkt_h::*;
#(
  parameter int DWIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  slot_sel_e              i_sel,
  input  pkHeadInfo              i_new_hdr,
  input  logic [DWIDTH-1:0]      i_new_data,
  input  logic [PRIOR_WIDTH-1:0] i_new_prior,
  input  logic                   i_left_valid,
  input  pkHeadInfo              i_left_hdr,
  input  logic [DWIDTH-1:0]      i_left_data,
  input  logic [PRIOR_WIDTH-1:0] i_left_prior,
  input  logic                   i_right_valid,
  input  pkHeadInfo              i_right_hdr,
  input  logic [DWIDTH-1:0]      i_right_data,
  input  logic [PRIOR_WIDTH-1:0] i_right_prior,
  output logic                   o_valid,
  output pkHeadInfo              o_hdr,
  output logic [DWIDTH-1:0]      o_data,
  output logic [PRIOR_WIDTH-1:0] o_prior,
  output logic                   o_ins
);

  logic                   r_valid;
  pkHeadInfo              r_hdr;
  logic [DWIDTH-1:0]      r_data;
  logic [PRIOR_WIDTH-1:0] r_prior;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_hdr   <= '0;
      r_data  <= '0;
      r_prior <= '0;
    end else begin
      case (i_sel)
        SEL_NEW: begin
          r_valid <= 1'b1;
          r_hdr   <= i_new_hdr;
          r_data  <= i_new_data;
          r_prior <= i_new_prior;
        end
        SEL_LEFT: begin
          r_valid <= i_left_valid;
          r_hdr   <= i_left_hdr;
          r_data  <= i_left_data;
          r_prior <= i_left_prior;
        end
        SEL_RIGHT: begin
          r_valid <= i_right_valid;
          r_hdr   <= i_right_hdr;
          r_data  <= i_right_data;
          r_prior <= i_right_prior;
        end
        default: ;
      endcase
    end
  end

  // Strict compare keeps ties in arrival order: equal priors stay ahead.
  assign o_ins   = !r_valid || (i_new_prior < r_prior);
  assign o_valid = r_valid;
  assign o_hdr   = r_hdr;
  assign o_data  = r_data;
  assign o_prior = r_prior;

endmodule

// File: rtl/pkt_priority_queue.sv
// ---------------------------------------------------------------------------
// pkt_priority_queue : register-based sorted priority queue of packet
// descriptors. Slot 0 always holds the lowest prior value; equal priors
// leave in arrival order.
//   clk          clock, all state on posedge
//   rst          asynchronous active-low reset
//   in_en        enqueue request
//   in_valid     1 = not full, enqueue accepted this cycle
//   in_pkt_info  256-bit packet header (prior taken from it)
//   in_data      data/address word stored with the header
//   out_en       dequeue request
//   out_valid    1 = non-empty, head outputs valid
//   out_data     head data word (0 when empty)
//   out_prior    head priority (0 when empty)
//
// Handshake: a transfer happens on a rising edge where request and the
// corresponding valid are both 1 (enqueue: in_en && in_valid, dequeue:
// out_en && out_valid). in_valid/out_valid depend only on the registered
// count, never on the same-cycle request, so a full queue refuses an
// enqueue even while it is being dequeued.
// ---------------------------------------------------------------------------
module pkt_priority_queue
  import pkt_h::*;
#(
  parameter int DWIDTH     = 64,
  parameter int QUEUE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  output logic                   in_valid,
  input  pkHeadInfo              in_pkt_info,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic                   out_en,
  output logic                   out_valid,
  output logic [DWIDTH-1:0]      out_data,
  output logic [PRIOR_WIDTH-1:0] out_prior
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic [CW-1:0]          r_count;
  logic                   w_enq;
  logic                   w_deq;
  logic [PRIOR_WIDTH-1:0] w_new_prior;

  // Index k+1 holds slot k; indices 0 and QUEUE_SIZE+1 are constant empty
  // neighbours for the two end slots.
  logic                   w_valid [QUEUE_SIZE+2];
  pkHeadInfo              w_hdr   [QUEUE_SIZE+2];
  logic [DWIDTH-1:0]      w_data  [QUEUE_SIZE+2];
  logic [PRIOR_WIDTH-1:0] w_prior [QUEUE_SIZE+2];
  // Index k = slot k; index QUEUE_SIZE is the empty position past the end.
  logic                   w_ins   [QUEUE_SIZE+1];

  assign in_valid    = (r_count < CW'(QUEUE_SIZE));
  assign out_valid   = (r_count != '0);
  assign w_enq       = in_en && in_valid;
  assign w_deq       = out_en && out_valid;
  assign w_new_prior = get_prior(in_pkt_info);

  assign w_valid[0]            = 1'b0;
  assign w_hdr[0]              = '0;
  assign w_data[0]             = '0;
  assign w_prior[0]            = '0;
  assign w_valid[QUEUE_SIZE+1] = 1'b0;
  assign w_hdr[QUEUE_SIZE+1]   = '0;
  assign w_data[QUEUE_SIZE+1]  = '0;
  assign w_prior[QUEUE_SIZE+1] = '0;
  assign w_ins[QUEUE_SIZE]     = 1'b1;

  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_slot
    slot_sel_e w_sel;
    logic      w_ins_lo;   // insert point is at or before slot i-1
    logic      w_gt_lo;    // slot i-1 is valid and moves up behind the insert
    logic      w_insr_lo;  // after dequeue, insert point is at or before position i-1

    if (i == 0) begin : g_first
      assign w_ins_lo  = 1'b0;
      assign w_gt_lo   = 1'b0;
      assign w_insr_lo = 1'b0;
    end else begin : g_rest
      assign w_ins_lo  = w_ins[i-1];
      assign w_gt_lo   = w_valid[i] && w_ins[i-1];
      assign w_insr_lo = w_ins[i];
    end

    // With a dequeue, position i of the post-dequeue order is slot i+1, so
    // the insert test uses the right neighbour's compare. Entries ahead of
    // the insert point shift down; those behind it stay put (shift down by
    // the dequeue, up by the insert).
    always_comb begin
      w_sel = SEL_HOLD;
      if (w_deq) begin
        if (w_enq && w_ins[i+1] && !w_insr_lo) begin
          w_sel = SEL_NEW;
        end else if (w_enq && w_insr_lo) begin
          w_sel = SEL_HOLD;
        end else begin
          w_sel = SEL_RIGHT;
        end
      end else if (w_enq) begin
        if (w_gt_lo) begin
          w_sel = SEL_LEFT;
        end else if (w_ins[i] && !w_ins_lo) begin
          w_sel = SEL_NEW;
        end
      end
    end

    pq_slot #(
      .DWIDTH(DWIDTH)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .i_sel         (w_sel),
      .i_new_hdr     (in_pkt_info),
      .i_new_data    (in_data),
      .i_new_prior   (w_new_prior),
      .i_left_valid  (w_valid[i]),
      .i_left_hdr    (w_hdr[i]),
      .i_left_data   (w_data[i]),
      .i_left_prior  (w_prior[i]),
      .i_right_valid (w_valid[i+2]),
      .i_right_hdr   (w_hdr[i+2]),
      .i_right_data  (w_data[i+2]),
      .i_right_prior (w_prior[i+2]),
      .o_valid       (w_valid[i+1]),
      .o_hdr         (w_hdr[i+1]),
      .o_data        (w_data[i+1]),
      .o_prior       (w_prior[i+1]),
      .o_ins         (w_ins[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data  = w_valid[1] ? w_data[1]  : '0;
  assign out_prior = w_valid[1] ? w_prior[1] : '0;

endmodule

// File: tb/tb_pkt_priority_queue.sv
module tb_pkt_priority_queue;
  import pkt_h::*;

  localparam int DW = 64;
  localparam int QS = 16;

  // ---------------- clock / reset ----------------
  logic            clk;
  logic            rst;
  logic            in_en;
  logic            in_valid;
  pkHeadInfo       in_pkt_info;
  logic [DW-1:0]   in_data;
  logic            out_en;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [15:0]     out_prior;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pkt_priority_queue #(
    .DWIDTH     (DW),
    .QUEUE_SIZE (QS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_en       (in_en),
    .in_valid    (in_valid),
    .in_pkt_info (in_pkt_info),
    .in_data     (in_data),
    .out_en      (out_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_prior   (out_prior)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [79:0] exp_q[$];   // {prior[15:0], data[63:0]} in expected dequeue order

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic ev, input logic [15:0] ep,
                          input logic [63:0] ed);
    chk({name, "_out_valid"}, {79'd0, out_valid}, {79'd0, ev});
    chk({name, "_out_prior"}, {64'd0, out_prior}, {64'd0, ep});
    chk({name, "_out_data"},  {16'd0, out_data},  {16'd0, ed});
  endtask

  // Stable insert: after every queued entry with prior <= p.
  task automatic model_insert(input logic [15:0] p, input logic [63:0] d);
    int idx;
    logic [79:0] e;
    idx = exp_q.size();
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      if (e[79:64] > p) begin
        idx = k;
        break;
      end
    end
    exp_q.insert(idx, {p, d});
  endtask

  // ---------------- driver ----------------
  // Header words other than the key are random, and the upper half of the
  // prior word is random too: only its low 16 bits may matter.
  function automatic pkHeadInfo mk_hdr(input logic [15:0] p);
    pkHeadInfo h;
    h.flow_id  = $urandom;
    h.src_addr = $urandom;
    h.dst_addr = $urandom;
    h.pkt_len  = $urandom;
    h.flags    = $urandom;
    h.ts_hi    = $urandom;
    h.ts_lo    = $urandom;
    h.prior    = {16'($urandom), p};
    return h;
  endfunction

  task automatic drive(input logic en, input logic oen, input logic [15:0] p,
                       input logic [63:0] d);
    in_en       = en;
    out_en      = oen;
    in_pkt_info = mk_hdr(p);
    in_data     = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic        oen;
    logic [15:0] p;
    logic [63:0] d;
    logic        e_iv;
    logic        e_ov;
    logic [15:0] e_p;
    logic [63:0] e_d;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mv(input logic en, input logic oen, input logic [15:0] p,
                              input logic [63:0] d, input logic e_iv, input logic e_ov,
                              input logic [15:0] e_p, input logic [63:0] e_d);
    vec_t v;
    v.en = en; v.oen = oen; v.p = p; v.d = d;
    v.e_iv = e_iv; v.e_ov = e_ov; v.e_p = e_p; v.e_d = e_d;
    return v;
  endfunction

  initial begin
    int          accepts;
    int          drained;
    logic [15:0] p;
    logic [79:0] e;

    // Order: 5A,2B,9C,2D -> 2B,2D,5A,9C
    vecs.push_back(mv(1, 0, 5, 64'hA1, 1, 1, 5, 64'hA1));
    vecs.push_back(mv(1, 0, 2, 64'hB2, 1, 1, 2, 64'hB2));
    vecs.push_back(mv(1, 0, 9, 64'hC3, 1, 1, 2, 64'hB2));
    vecs.push_back(mv(1, 0, 2, 64'hD4, 1, 1, 2, 64'hB2));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 2, 64'hD4));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 5, 64'hA1));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 9, 64'hC3));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    // Dequeue on empty is ignored
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    // Simultaneous: {3,7} + enq 1 with deq -> {1,7}
    vecs.push_back(mv(1, 0, 3, 64'hE5, 1, 1, 3, 64'hE5));
    vecs.push_back(mv(1, 0, 7, 64'hF6, 1, 1, 3, 64'hE5));
    vecs.push_back(mv(1, 1, 1, 64'h17, 1, 1, 1, 64'h17));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 7, 64'hF6));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    // Simultaneous with one entry: new entry becomes head even if larger
    vecs.push_back(mv(1, 0, 4, 64'h28, 1, 1, 4, 64'h28));
    vecs.push_back(mv(1, 1, 8, 64'h39, 1, 1, 8, 64'h39));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    // Ties keep arrival order, smaller value jumps ahead
    vecs.push_back(mv(1, 0, 6, 64'h4A, 1, 1, 6, 64'h4A));
    vecs.push_back(mv(1, 0, 6, 64'h5B, 1, 1, 6, 64'h4A));
    vecs.push_back(mv(1, 0, 0, 64'h6C, 1, 1, 0, 64'h6C));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 6, 64'h4A));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 6, 64'h5B));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 0, 0, 64'h0));
    // Simultaneous where the new entry lands behind the new head
    vecs.push_back(mv(1, 0, 2, 64'h7D, 1, 1, 2, 64'h7D));
    vecs.push_back(mv(1, 0, 5, 64'h8E, 1, 1, 2, 64'h7D));
    vecs.push_back(mv(1, 1, 9, 64'h9F, 1, 1, 5, 64'h8E));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 1, 9, 64'h9F));
    vecs.push_back(mv(0, 1, 0, 64'h0,  1, 0, 0, 64'h0));

    // ---- reset ----
    rst = 1'b1;
    drive(0, 0, 0, 64'h0);
    #2 rst = 1'b0;
    #10;
    chk("rst_in_valid", {79'd0, in_valid}, 80'd1);
    chk_head("rst", 1'b0, 16'd0, 64'd0);
    #10 rst = 1'b1;
    tick();
    chk("rel_in_valid", {79'd0, in_valid}, 80'd1);
    chk_head("rel", 1'b0, 16'd0, 64'd0);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].oen, vecs[i].p, vecs[i].d);
      tick();
      chk($sformatf("vec%0d_in_valid", i), {79'd0, in_valid}, {79'd0, vecs[i].e_iv});
      chk_head($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_p, vecs[i].e_d);
    end

    // ---- fill with random priors ----
    accepts = 0;
    for (int c = 0; c < QS + 4; c++) begin
      p = 16'($urandom_range(0, 7));
      drive(1, 0, p, 64'h1000 + 64'(c));
      if (in_valid) begin
        accepts++;
        model_insert(p, 64'h1000 + 64'(c));
      end
      tick();
    end
    chk("fill_accepts", 80'(accepts), 80'(QS));
    chk("fill_in_valid", {79'd0, in_valid}, 80'd0);
    e = exp_q[0];
    chk_head("fill", 1'b1, e[79:64], e[63:0]);

    // ---- full + dequeue: head leaves, new entry dropped ----
    drive(1, 1, 16'd0, 64'hDEAD);
    chk("full_deq_in_valid_before", {79'd0, in_valid}, 80'd0);
    tick();
    e = exp_q.pop_front();
    chk("full_deq_in_valid_after", {79'd0, in_valid}, 80'd1);
    e = exp_q[0];
    chk_head("full_deq", 1'b1, e[79:64], e[63:0]);

    // ---- drain, checking order; count must be 15 ----
    drive(0, 1, 0, 64'h0);
    drained = 0;
    while (out_valid && drained < 40) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("drain%0d_prior", drained), {64'd0, out_prior}, {64'd0, e[79:64]});
        chk($sformatf("drain%0d_data", drained), {16'd0, out_data}, {16'd0, e[63:0]});
      end
      drained++;
      tick();
    end
    chk("drain_count", 80'(drained), 80'(QS - 1));
    chk("drain_empty", {79'd0, out_valid}, 80'd0);

    // ---- async reset mid-stream with 8 entries ----
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 16'(k + 20), 64'h2000 + 64'(k));
      tick();
    end
    drive(0, 0, 0, 64'h0);
    chk_head("pre_arst", 1'b1, 16'd20, 64'h2000);
    #3 rst = 1'b0;
    #1;
    chk("arst_in_valid", {79'd0, in_valid}, 80'd1);
    chk_head("arst", 1'b0, 16'd0, 64'd0);
    #2 rst = 1'b1;
    tick();
    chk("arst_rel_in_valid", {79'd0, in_valid}, 80'd1);
    chk_head("arst_rel", 1'b0, 16'd0, 64'd0);
    drive(1, 0, 16'd30, 64'hBEEF);
    tick();
    chk_head("arst_enq", 1'b1, 16'd30, 64'hBEEF);
    drive(0, 1, 0, 64'h0);
    tick();
    chk_head("arst_only_one", 1'b0, 16'd0, 64'd0);
    drive(0, 0, 0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
